// File: rtl/uart_fifo.sv
// uart_fifo: buffered UART with TX and RX engines, each fronted by a FIFO.
//
// Optional feature: define UART_PARITY_EN to add an even parity bit (XOR of the
// data bits) after the data bits on TX, and a parity check on RX that sets the
// sticky rx_parity_err_o flag. Without it, rx_parity_err_o is tied to 0.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   send_req_valid_i/ready_o     byte to transmit (push into TX FIFO)
//   send_req_data_i
//   recv_rsp_valid_o/ready_i     received byte (FIFO head, first-word fall-through)
//   recv_rsp_data_o
//   serial_in_i                  RX line, asynchronous
//   serial_out_o                 TX line, registered
//   tx_level_o, rx_level_o       FIFO occupancies
//   tx_busy_o                    TX FIFO non-empty or frame in flight
//   err_clr_i                    clears all sticky error flags (wins over a set)
//   rx_overrun_o                 sticky: byte received while RX FIFO full
//   rx_frame_err_o               sticky: first stop bit sampled 0
//   rx_parity_err_o              sticky: parity mismatch (UART_PARITY_EN only)
module uart_fifo #(
    parameter int unsigned CLOCK_FREQ = 125_000_000,
    parameter int unsigned BAUD_RATE  = 115_200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned TX_DEPTH   = 16,
    parameter int unsigned RX_DEPTH   = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        send_req_valid_i,
    output logic                        send_req_ready_o,
    input  logic [DATA_BITS-1:0]        send_req_data_i,
    output logic                        recv_rsp_valid_o,
    input  logic                        recv_rsp_ready_i,
    output logic [DATA_BITS-1:0]        recv_rsp_data_o,
    input  logic                        serial_in_i,
    output logic                        serial_out_o,
    output logic [$clog2(TX_DEPTH):0]   tx_level_o,
    output logic [$clog2(RX_DEPTH):0]   rx_level_o,
    output logic                        tx_busy_o,
    input  logic                        err_clr_i,
    output logic                        rx_overrun_o,
    output logic                        rx_frame_err_o,
    output logic                        rx_parity_err_o
);

    localparam int unsigned CPB = (CLOCK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int unsigned TAW = $clog2(TX_DEPTH);
    localparam int unsigned RAW = $clog2(RX_DEPTH);
    localparam int unsigned CW  = $clog2(STOP_BITS * CPB + 1);
    localparam int unsigned BW  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] tx_mem_q [TX_DEPTH];
    logic [TAW:0]         tx_wptr_q, tx_rptr_q;
    logic                 tx_empty, tx_full, tx_push, tx_pop;
    logic [DATA_BITS-1:0] tx_head;

    assign tx_empty = (tx_wptr_q == tx_rptr_q);
    assign tx_full  = (tx_wptr_q[TAW] != tx_rptr_q[TAW]) &&
                      (tx_wptr_q[TAW-1:0] == tx_rptr_q[TAW-1:0]);
    assign tx_push  = send_req_valid_i && !tx_full;
    assign tx_head  = tx_mem_q[tx_rptr_q[TAW-1:0]];

    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem_q[tx_wptr_q[TAW-1:0]] <= send_req_data_i;
    end

    // ---------------- TX engine ----------------
    state_e               tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_line_q, tx_line_d;
    logic                 tx_load;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = (tx_state_q == StIdle) ? tx_cnt_q : tx_cnt_q - CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        tx_load    = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        unique case (tx_state_q)
            StIdle: tx_load = !tx_empty;
            StStart: if (tx_cnt_q == '0) begin
                tx_state_d = StData;
                tx_cnt_d   = CW'(CPB - 1);
                tx_bit_d   = '0;
                tx_line_d  = tx_shift_q[0];
            end
            StData: if (tx_cnt_q == '0) begin
                if (tx_bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                    tx_state_d = StParity;
                    tx_cnt_d   = CW'(CPB - 1);
                    tx_line_d  = tx_par_q;
`else
                    tx_state_d = StStop;
                    tx_cnt_d   = CW'(STOP_BITS * CPB - 1);
                    tx_line_d  = 1'b1;
`endif
                end else begin
                    tx_bit_d   = tx_bit_q + BW'(1);
                    tx_shift_d = tx_shift_q >> 1;
                    tx_cnt_d   = CW'(CPB - 1);
                    tx_line_d  = tx_shift_q[1];
                end
            end
            StParity: if (tx_cnt_q == '0) begin
                tx_state_d = StStop;
                tx_cnt_d   = CW'(STOP_BITS * CPB - 1);
                tx_line_d  = 1'b1;
            end
            StStop: if (tx_cnt_q == '0) begin
                // Chain straight into the next start bit when more data waits.
                tx_load    = !tx_empty;
                tx_state_d = StIdle;
                tx_line_d  = 1'b1;
            end
            default: begin
                tx_state_d = StIdle;
                tx_line_d  = 1'b1;
            end
        endcase
        if (tx_load) begin
            tx_state_d = StStart;
            tx_cnt_d   = CW'(CPB - 1);
            tx_shift_d = tx_head;
            tx_line_d  = 1'b0;
`ifdef UART_PARITY_EN
            tx_par_d   = ^tx_head;
`endif
        end
    end

    assign tx_pop = tx_load;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            tx_state_q <= StIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + (TAW + 1)'(1);
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + (TAW + 1)'(1);
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    assign send_req_ready_o = !tx_full;
    assign serial_out_o     = tx_line_q;
    assign tx_level_o       = tx_wptr_q - tx_rptr_q;
    assign tx_busy_o        = !tx_empty || (tx_state_q != StIdle);

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS-1:0] rx_mem_q [RX_DEPTH];
    logic [RAW:0]         rx_wptr_q, rx_rptr_q;
    logic                 rx_empty, rx_full, rx_push, rx_pop, rx_wr_req;

    assign rx_empty = (rx_wptr_q == rx_rptr_q);
    assign rx_full  = (rx_wptr_q[RAW] != rx_rptr_q[RAW]) &&
                      (rx_wptr_q[RAW-1:0] == rx_rptr_q[RAW-1:0]);
    assign rx_push  = rx_wr_req && !rx_full;
    assign rx_pop   = !rx_empty && recv_rsp_ready_i;

    // ---------------- RX engine ----------------
    logic [1:0]           rx_sync_q;
    logic                 rx_prev_q, rx_line;
    state_e               rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_over_q, rx_over_d, rx_frame_q, rx_frame_d;
`ifdef UART_PARITY_EN
    logic                 rx_par_q, rx_par_d;
`endif

    assign rx_line = rx_sync_q[1];

    always_ff @(posedge clk_i) begin
        if (rx_push) rx_mem_q[rx_wptr_q[RAW-1:0]] <= rx_shift_q;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = (rx_state_q == StIdle) ? rx_cnt_q : rx_cnt_q - CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_wr_req  = 1'b0;
        rx_over_d  = rx_over_q;
        rx_frame_d = rx_frame_q;
`ifdef UART_PARITY_EN
        rx_par_d   = rx_par_q;
`endif
        unique case (rx_state_q)
            StIdle: if (rx_prev_q && !rx_line) begin
                rx_state_d = StStart;
                rx_cnt_d   = CW'(CPB / 2 - 1);
            end
            StStart: if (rx_cnt_q == '0) begin
                // High at mid start bit: treat the edge as a glitch.
                rx_state_d = rx_line ? StIdle : StData;
                rx_cnt_d   = CW'(CPB - 1);
                rx_bit_d   = '0;
            end
            StData: if (rx_cnt_q == '0) begin
                rx_shift_d = {rx_line, rx_shift_q[DATA_BITS-1:1]};
                rx_cnt_d   = CW'(CPB - 1);
                if (rx_bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                    rx_state_d = StParity;
`else
                    rx_state_d = StStop;
`endif
                end else begin
                    rx_bit_d = rx_bit_q + BW'(1);
                end
            end
            StParity: if (rx_cnt_q == '0) begin
`ifdef UART_PARITY_EN
                if (rx_line != ^rx_shift_q) rx_par_d = 1'b1;
`endif
                rx_state_d = StStop;
                rx_cnt_d   = CW'(CPB - 1);
            end
            StStop: if (rx_cnt_q == '0) begin
                if (!rx_line) rx_frame_d = 1'b1;
                rx_wr_req  = 1'b1;
                rx_state_d = StIdle;
            end
            default: rx_state_d = StIdle;
        endcase
        if (rx_wr_req && rx_full) rx_over_d = 1'b1;
        if (err_clr_i) begin
            rx_over_d  = 1'b0;
            rx_frame_d = 1'b0;
`ifdef UART_PARITY_EN
            rx_par_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_sync_q  <= 2'b11;
            rx_prev_q  <= 1'b1;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_state_q <= StIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_over_q  <= 1'b0;
            rx_frame_q <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_q   <= 1'b0;
`endif
        end else begin
            rx_sync_q  <= {rx_sync_q[0], serial_in_i};
            rx_prev_q  <= rx_line;
            if (rx_push) rx_wptr_q <= rx_wptr_q + (RAW + 1)'(1);
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + (RAW + 1)'(1);
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_over_q  <= rx_over_d;
            rx_frame_q <= rx_frame_d;
`ifdef UART_PARITY_EN
            rx_par_q   <= rx_par_d;
`endif
        end
    end

    assign recv_rsp_valid_o = !rx_empty;
    assign recv_rsp_data_o  = rx_mem_q[rx_rptr_q[RAW-1:0]];
    assign rx_level_o       = rx_wptr_q - rx_rptr_q;
    assign rx_overrun_o     = rx_over_q;
    assign rx_frame_err_o   = rx_frame_q;
`ifdef UART_PARITY_EN
    assign rx_parity_err_o  = rx_par_q;
`else
    assign rx_parity_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: self-checking bench for uart_fifo (CPB = 10, 8N1, depth 4).
// Table of TX frames, hand-written RX corner sequences, and a randomized
// loopback run checked against a byte queue.
module tb_uart_fifo;
    localparam int CPB = 10;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       send_valid, send_ready;
    logic [7:0] send_data;
    logic       recv_valid, recv_ready;
    logic [7:0] recv_data;
    logic       serial_in, serial_out, line_drv, loop_en;
    logic [2:0] tx_level, rx_level;
    logic       tx_busy, err_clr, rx_overrun, rx_frame_err, rx_parity_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign serial_in = loop_en ? serial_out : line_drv;

    uart_fifo #(
        .CLOCK_FREQ(1_000_000),
        .BAUD_RATE (100_000),
        .DATA_BITS (8),
        .STOP_BITS (1),
        .TX_DEPTH  (4),
        .RX_DEPTH  (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .send_req_valid_i(send_valid),
        .send_req_ready_o(send_ready),
        .send_req_data_i (send_data),
        .recv_rsp_valid_o(recv_valid),
        .recv_rsp_ready_i(recv_ready),
        .recv_rsp_data_o (recv_data),
        .serial_in_i     (serial_in),
        .serial_out_o    (serial_out),
        .tx_level_o      (tx_level),
        .rx_level_o      (rx_level),
        .tx_busy_o       (tx_busy),
        .err_clr_i       (err_clr),
        .rx_overrun_o    (rx_overrun),
        .rx_frame_err_o  (rx_frame_err),
        .rx_parity_err_o (rx_parity_err)
    );

    typedef struct {
        logic [7:0] data;
        logic       par;   // expected even-parity bit
    } tx_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Frame rule: start 0, data LSB first, [even parity], stop 1.
    function automatic logic frame_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
        if (FB == 11 && i == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic push(input logic [7:0] d);
        int t = 0;
        while (!send_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!send_ready) chk("push_timeout", 0, 1);
        send_valid = 1'b1;
        send_data  = d;
        @(negedge clk);
        send_valid = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        int t = 0;
        while (serial_out !== 1'b0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        ok = (serial_out === 1'b0);
        if (!ok) chk("tx_start_timeout", 0, 1);
    endtask

    // Capture one frame, sampling at bit centres; returns bits in order.
    task automatic capture(output logic [10:0] f);
        f = '1;
        tick(5);
        for (int i = 0; i < FB; i++) begin
            f[i] = serial_out;
            if (i < FB - 1) tick(CPB);
        end
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop, input logic par);
        line_drv = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            line_drv = d[i];
            tick(CPB);
        end
        if (FB == 11) begin
            line_drv = par;
            tick(CPB);
        end
        line_drv = stop;
        tick(CPB);
        line_drv = 1'b1;
        tick(CPB);
    endtask

    task automatic pop_expect(input string name, input logic [7:0] exp);
        chk({name, "_valid"}, recv_valid, 1);
        chk({name, "_data"}, recv_data, exp);
        recv_ready = 1'b1;
        @(negedge clk);
        recv_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tx_vec_t    tv [6];
        logic [7:0] exp_q [$];
        logic [10:0] f, ef;
        logic [7:0] b2b [6];
        bit         ok;
        int         got;

        tv[0] = '{8'hA5, 1'b0};
        tv[1] = '{8'h00, 1'b0};
        tv[2] = '{8'hFF, 1'b0};
        tv[3] = '{8'h3C, 1'b0};
        tv[4] = '{8'h07, 1'b1};
        tv[5] = '{8'h80, 1'b1};

        rst = 1'b1; send_valid = 1'b0; send_data = '0; recv_ready = 1'b0;
        line_drv = 1'b1; loop_en = 1'b0; err_clr = 1'b0;
        tick(3);
        rst = 1'b0;

        // Reset state
        chk("rst_serial_out", serial_out, 1);
        chk("rst_ready", send_ready, 1);
        chk("rst_recv_valid", recv_valid, 0);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_rx_level", rx_level, 0);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_errors", {rx_overrun, rx_frame_err, rx_parity_err}, 0);

        // Table-driven single frames
        for (int v = 0; v < 6; v++) begin
            push(tv[v].data);
            wait_start(ok);
            if (ok) begin
                capture(f);
                if (FB == 11) ef = {1'b1, tv[v].par, tv[v].data, 1'b0};
                else          ef = {2'b11, tv[v].data, 1'b0};
                chk($sformatf("tx_frame_%0h", tv[v].data), f, ef);
                tick(4);
                chk("tx_busy_last_cycle", tx_busy, 1);
                tick(1);
                chk("tx_busy_done", tx_busy, 0);
            end
        end

        // Back-to-back pushes; frames must be contiguous
        for (int k = 0; k < 6; k++) b2b[k] = 8'(k + 1);
        fork
            begin
                send_valid = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    send_data = b2b[k];
                    chk("b2b_ready", send_ready, 1);
                    @(negedge clk);
                end
                chk("b2b_full_ready", send_ready, 0);
                chk("b2b_full_level", tx_level, 4);
                send_valid = 1'b0;
                push(b2b[5]);
            end
            begin
                wait_start(ok);
                for (int k = 0; k < 6; k++) begin
                    capture(f);
                    ef = '1;
                    for (int i = 0; i < FB; i++) ef[i] = frame_bit(b2b[k], i);
                    chk($sformatf("b2b_frame_%0d", k), f, ef);
                    tick(5);
                end
            end
        join
        tick(2 * CPB);
        chk("b2b_idle", tx_busy, 0);

        // Randomized loopback against a byte queue
        loop_en = 1'b1;
        got = 0;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    logic [7:0] d;
                    d = (k == 0) ? 8'h3C : (k == 1) ? 8'hC3 : 8'($urandom);
                    tick($urandom_range(0, 150));
                    exp_q.push_back(d);
                    push(d);
                end
            end
            begin
                int t = 0;
                while (got < 10 && t < 8000) begin
                    recv_ready = 1'($urandom);
                    if (recv_valid && recv_ready) begin
                        if (exp_q.size() == 0) chk("loop_unexpected_byte", recv_data, 0);
                        else chk("loop_data", recv_data, exp_q.pop_front());
                        got++;
                    end
                    @(negedge clk);
                    t++;
                end
                recv_ready = 1'b0;
                chk("loop_count", got, 10);
            end
        join
        chk("loop_errors", {rx_overrun, rx_frame_err, rx_parity_err}, 0);
        chk("loop_rx_level", rx_level, 0);
        loop_en = 1'b0;
        tick(CPB);

        // Overrun: five frames into a depth-4 FIFO
        drive_frame(8'h11, 1'b1, 1'b0);
        drive_frame(8'h22, 1'b1, 1'b0);
        drive_frame(8'h33, 1'b1, 1'b0);
        drive_frame(8'h44, 1'b1, 1'b0);
        chk("ovr_not_yet", rx_overrun, 0);
        drive_frame(8'h55, 1'b1, 1'b0);
        chk("ovr_level", rx_level, 4);
        chk("ovr_flag", rx_overrun, 1);
        chk("ovr_frame_err", rx_frame_err, 0);
        pulse_clr();
        chk("ovr_cleared", rx_overrun, 0);
        pop_expect("ovr_pop0", 8'h11);
        pop_expect("ovr_pop1", 8'h22);
        pop_expect("ovr_pop2", 8'h33);
        pop_expect("ovr_pop3", 8'h44);
        chk("ovr_drained", rx_level, 0);
        chk("ovr_drained_valid", recv_valid, 0);

        // Stop bit low: byte still written, frame error set
        drive_frame(8'h5A, 1'b0, 1'b0);
        chk("ferr_flag", rx_frame_err, 1);
        chk("ferr_level", rx_level, 1);
        pop_expect("ferr_pop", 8'h5A);
        pulse_clr();
        chk("ferr_cleared", rx_frame_err, 0);

        // 3-cycle low glitch: ignored
        line_drv = 1'b0;
        tick(3);
        line_drv = 1'b1;
        tick(4 * CPB);
        chk("glitch_level", rx_level, 0);
        chk("glitch_errors", {rx_overrun, rx_frame_err, rx_parity_err}, 0);

`ifdef UART_PARITY_EN
        drive_frame(8'h07, 1'b1, 1'b0);
        chk("perr_flag", rx_parity_err, 1);
        pop_expect("perr_pop", 8'h07);
        pulse_clr();
        chk("perr_cleared", rx_parity_err, 0);
`endif

        // Reset in the middle of a data bit
        push(8'h00);
        push(8'hFF);
        wait_start(ok);
        tick(25);
        chk("mid_serial_out", serial_out, 0);
        chk("mid_tx_level", tx_level, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_serial_out", serial_out, 1);
        chk("rstmid_tx_level", tx_level, 0);
        chk("rstmid_tx_busy", tx_busy, 0);
        rst = 1'b0;
        tick(5);
        chk("rstmid_stays_idle", serial_out, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
